// File: rtl/rc_batch_sequencer_if.sv
// Stream and core-bus signals of the Reinforced Concrete batch sequencer.
// The master modport is the sequencer's view; slave is the host/core environment's view.
interface rc_batch_sequencer_if #(
    parameter int N_BITS = 254
);
    logic [N_BITS-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [N_BITS-1:0] core_inState;
    logic [1:0]        core_wr;
    logic [1:0]        core_rd;
    logic              core_enable;
    logic              core_reset;
    logic [N_BITS-1:0] core_outState;
    logic              core_done;

    modport master (
        input  in_data, in_valid, out_ready, core_outState, core_done,
        output in_ready, out_data, out_valid, out_last,
               core_inState, core_wr, core_rd, core_enable, core_reset
    );

    modport slave (
        output in_data, in_valid, out_ready, core_outState, core_done,
        input  in_ready, out_data, out_valid, out_last,
               core_inState, core_wr, core_rd, core_enable, core_reset
    );
endinterface

// File: rtl/rc_batch_sequencer.sv
// Host-side sequencer for the two-bank Reinforced Concrete core: loads a batch,
// runs the core, drains the results and resets the core between batches.
module rc_batch_sequencer #(
    parameter int N_BITS         = 254,
    parameter int WORDS_PER_BANK = 39,
    parameter int DONE_TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    rc_batch_sequencer_if.master bus,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int TOTAL = 2 * WORDS_PER_BANK;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    localparam logic [CW-1:0] BANK_WORDS = CW'(WORDS_PER_BANK);
    localparam logic [CW-1:0] LAST_CNT   = CW'(TOTAL);
    localparam logic [CW-1:0] LAST_IDX   = CW'(TOTAL - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DONE_TIMEOUT - 1);

    localparam logic [2:0] S_CRST  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [N_BITS-1:0] out_data_q, out_data_d;
    logic              timeout_err_q, timeout_err_d;

    logic              in_ready_s;
    logic              in_hs_s;
    logic              rd_issue_s;

    // Handshake and read-issue qualifiers; strobes are held off while reset is applied.
    always_comb begin
        in_ready_s = (state_q == S_LOAD) && !reset;
        in_hs_s    = in_ready_s && bus.in_valid;
        rd_issue_s = (state_q == S_DRAIN) && !reset && !rd_inflight_q
                     && (!out_valid_q || bus.out_ready) && (rd_cnt_q < LAST_CNT);
    end

    // Next-state and datapath update for the batch sequence.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        timer_d       = timer_q;
        rd_inflight_d = rd_inflight_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_CRST: begin
                word_cnt_d    = '0;
                rd_cnt_d      = '0;
                rd_inflight_d = 1'b0;
                state_d       = S_LOAD;
            end
            S_LOAD: begin
                if (in_hs_s) begin
                    word_cnt_d = word_cnt_q + CW'(1);
                    state_d    = (word_cnt_q == LAST_IDX) ? S_START : S_LOAD;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // core_done wins over a coinciding timeout
                if (bus.core_done) begin
                    state_d = S_DRAIN;
                end else if ((DONE_TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_CRST;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (rd_inflight_q) begin
                    // out_valid is always low here: a read is only issued once the slot is free
                    out_data_d    = bus.core_outState;
                    out_valid_d   = 1'b1;
                    out_last_d    = (rd_cnt_q == LAST_CNT);
                    rd_inflight_d = 1'b0;
                end else begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = out_last_q ? S_CRST : S_DRAIN;
                    end else begin
                        out_valid_d = out_valid_q;
                    end
                    if (rd_issue_s) begin
                        rd_cnt_d      = rd_cnt_q + CW'(1);
                        rd_inflight_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q;
                    end
                end
            end
            default: begin
                state_d = S_CRST;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_CRST;
            word_cnt_q    <= '0;
            rd_cnt_q      <= '0;
            timer_q       <= '0;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            timer_q       <= timer_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Core strobes: bank 1 for the first WORDS_PER_BANK words, bank 2 for the rest.
    assign bus.core_wr      = in_hs_s ? ((word_cnt_q < BANK_WORDS) ? 2'b01 : 2'b10) : 2'b00;
    assign bus.core_rd      = rd_issue_s ? ((rd_cnt_q < BANK_WORDS) ? 2'b01 : 2'b10) : 2'b00;
    assign bus.core_inState = bus.in_data;
    assign bus.core_enable  = ((state_q == S_START) || (state_q == S_WAIT)) && !reset;
    assign bus.core_reset   = (state_q == S_CRST) && !reset;
    assign bus.in_ready     = in_ready_s;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign busy             = !((state_q == S_LOAD) && (word_cnt_q == '0));
    assign timeout_err      = timeout_err_q;
endmodule

// File: tb/tb_rc_batch_sequencer.sv
// Scoreboard bench for rc_batch_sequencer with a behavioural two-bank core model
// whose result for batch position p is core_f(word, p).
module tb_rc_batch_sequencer;
    localparam int NB  = 254;
    localparam int WPB = 39;
    localparam int TOT = 78;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic timeout_err;
    int   total = 0;
    int   bad   = 0;

    rc_batch_sequencer_if #(.N_BITS(NB)) bif ();

    rc_batch_sequencer #(.N_BITS(NB), .WORDS_PER_BANK(WPB), .DONE_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bif.master), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] core_f(input logic [NB-1:0] x, input int pos);
        logic [NB-1:0] p;
        p = NB'(pos + 1);
        return x ^ (p << 240) ^ (p * NB'(7919));
    endfunction

    function automatic logic [NB-1:0] rnd();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r[NB-1:0];
    endfunction

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural core ----------------
    logic [NB-1:0] bank0 [0:WPB-1];
    logic [NB-1:0] bank1 [0:WPB-1];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0, en_cnt = 0;
    logic          core_done_r = 1'b0;
    logic [NB-1:0] core_out_r  = '0;
    bit            never_done  = 1'b0;
    assign bif.core_done     = core_done_r;
    assign bif.core_outState = core_out_r;

    always @(posedge clk) begin
        if (bif.core_reset) begin
            wp0 <= 0; wp1 <= 0; rp0 <= 0; rp1 <= 0; en_cnt <= 0; core_done_r <= 1'b0;
        end else begin
            if (bif.core_wr == 2'b01 && wp0 < WPB) begin bank0[wp0] <= bif.core_inState; wp0 <= wp0 + 1; end
            if (bif.core_wr == 2'b10 && wp1 < WPB) begin bank1[wp1] <= bif.core_inState; wp1 <= wp1 + 1; end
            if (bif.core_enable && !core_done_r) begin
                en_cnt <= en_cnt + 1;
                if (en_cnt == 9 && !never_done) core_done_r <= 1'b1;
            end
            if (bif.core_rd == 2'b01 && rp0 < WPB) begin
                core_out_r <= core_f(bank0[rp0], rp0); rp0 <= rp0 + 1;
            end else if (bif.core_rd == 2'b10 && rp1 < WPB) begin
                core_out_r <= core_f(bank1[rp1], WPB + rp1); rp1 <= rp1 + 1;
            end
        end
    end

    // ---------------- scoreboard, monitors ----------------
    logic [NB-1:0] exp_d [$];
    bit            exp_l [$];
    int            rdy_mode = 0;
    int            en_cycles = 0;
    int            crst_cnt = 0;
    logic          mon_stall = 1'b0;
    logic [NB-1:0] mon_held = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    chk("hold_valid", bif.out_valid, 1);
                    chk("hold_data", bif.out_data, mon_held);
                end
                if (bif.out_valid && bif.out_ready) begin
                    if (exp_d.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out actual=%0h required=none", bif.out_data);
                    end else begin
                        chk("out_data", bif.out_data, exp_d.pop_front());
                        chk("out_last", bif.out_last, exp_l.pop_front());
                    end
                end
                mon_stall = bif.out_valid && !bif.out_ready;
                mon_held  = bif.out_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bif.core_enable) en_cycles++;
            if (bif.core_reset) crst_cnt++;
            if (!reset) begin
                total++;
                if ((bif.core_wr != 2'b00 && bif.core_rd != 2'b00) || !$onehot0(bif.core_wr)
                    || !$onehot0(bif.core_rd)
                    || (bif.core_rd != 2'b00 && bif.out_valid && !bif.out_ready)) begin
                    bad++;
                    $display("FAIL strobe_rule actual wr=%b rd=%b ov=%b or=%b required=legal",
                             bif.core_wr, bif.core_rd, bif.out_valid, bif.out_ready);
                end
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        bif.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin bif.out_ready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
                2: bif.out_ready = ($urandom_range(0, 1) == 1);
                default: bif.out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic send_words(input int n, input bit gaps, input bit seq, input bit push);
        int k, c;
        logic [NB-1:0] w;
        k = 0; c = 0;
        w = seq ? NB'(1) : rnd();
        while (k < n && c < 4000) begin
            @(posedge clk); #1;
            c++;
            if (gaps && (c % 3 == 0)) begin
                bif.in_valid = 1'b0; bif.in_data = rnd();
                @(negedge clk);
                if (bif.in_ready) chk("wr_gap", bif.core_wr, 0);
            end else begin
                bif.in_valid = 1'b1; bif.in_data = w;
                @(negedge clk);
                if (bif.in_ready) begin
                    chk("core_wr", bif.core_wr, (k < WPB) ? 2'b01 : 2'b10);
                    chk("core_inState", bif.core_inState, w);
                    if (push) begin exp_d.push_back(core_f(w, k)); exp_l.push_back(k == TOT - 1); end
                    k++;
                    w = seq ? NB'(k + 1) : rnd();
                end
            end
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        total++;
        if (k < n) begin bad++; $display("FAIL load_stall actual=%0d required=%0d", k, n); end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_d.size() == 0 && bif.in_ready) && n < 3000) begin @(negedge clk); n++; end
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s_idle actual=%0d_left required=0_left", tag, exp_d.size());
        end
    endtask

    task automatic run_batch(input string tag, input bit gaps, input bit seq, input int rmode);
        int e0, c0;
        rdy_mode = rmode;
        send_words(TOT, gaps, seq, 1'b1);
        e0 = en_cycles; c0 = crst_cnt;
        @(negedge clk);
        chk({tag, "_enable"}, bif.core_enable, 1);
        chk({tag, "_in_ready_off"}, bif.in_ready, 0);
        wait_idle(tag);
        chk({tag, "_enable_cycles"}, NB'(en_cycles - e0), NB'(11));
        chk({tag, "_core_resets"}, NB'(crst_cnt - c0), NB'(1));
    endtask

    initial begin
        int e0, c0, n;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bif.in_ready, 0);
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_out_last", bif.out_last, 0);
        chk("rst_core_wr", bif.core_wr, 0);
        chk("rst_core_rd", bif.core_rd, 0);
        chk("rst_core_enable", bif.core_enable, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_busy", busy, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("crst_pulse", bif.core_reset, 1);
        @(negedge clk);
        chk("crst_end", bif.core_reset, 0);
        chk("load_ready", bif.in_ready, 1);
        chk("load_idle", busy, 0);

        run_batch("seq", 1'b0, 1'b1, 0);
        run_batch("stall", 1'b0, 1'b0, 1);
        run_batch("gaps", 1'b1, 1'b0, 2);

        // core never finishes: timeout after START + 16 WAIT cycles, batch dropped
        never_done = 1'b1;
        rdy_mode = 0;
        send_words(TOT, 1'b0, 1'b0, 1'b0);
        e0 = en_cycles; c0 = crst_cnt; n = 0;
        @(negedge clk);
        while (!timeout_err && n < 60) begin @(negedge clk); n++; end
        chk("timeout_err", timeout_err, 1);
        chk("timeout_enable_cycles", NB'(en_cycles - e0), NB'(17));
        wait_idle("timeout");
        chk("timeout_core_resets", NB'(crst_cnt - c0), NB'(1));
        never_done = 1'b0;

        run_batch("post_timeout", 1'b0, 1'b0, 2);
        chk("timeout_sticky", timeout_err, 1);

        // reset in the middle of loading
        rdy_mode = 0;
        send_words(50, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        exp_d.delete();
        exp_l.delete();
        @(negedge clk);
        chk("midrst_in_ready", bif.in_ready, 0);
        chk("midrst_core_wr", bif.core_wr, 0);
        @(negedge clk);
        chk("midrst_out_valid", bif.out_valid, 0);
        chk("midrst_busy", busy, 1);
        c0 = crst_cnt;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_core_resets", NB'(crst_cnt - c0), NB'(1));
        chk("midrst_ready", bif.in_ready, 1);
        run_batch("fresh", 1'b0, 1'b1, 0);

        run_batch("back_a", 1'b0, 1'b0, 2);
        run_batch("back_b", 1'b1, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rc_batch_sequencer.md
Name: rc_batch_sequencer

Overview:
- Host-side driver for the two-bank Reinforced Concrete permutation core wrapper.
- Accepts a stream of 78 field elements, in_data. Writes them into bank 1 and then bank 2 of the core through its wr strobes, then starts the core and waits for done.
- Drains the 78 results through the core's rd strobes and presents them on a valid/ready output stream.
- Re-initialises the core between batches, because the core's write and read pointers saturate at 39 and only return to zero on reset.

Parameters:
- N_BITS, 254, field element width.
- WORDS_PER_BANK, 39, words per bank (13 instances × state size 3).
- DONE_TIMEOUT, 4096, maximum cycles to wait for core_done. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  N_BITS  input element
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data this cycle
- out_data  out  N_BITS  result element
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  marks the 78th result of a batch
- core_inState  out  N_BITS  data to core
- core_wr  out  2  core write strobes (one-hot or zero)
- core_rd  out  2  core read strobes (one-hot or zero)
- core_enable  out  1  core run enable
- core_reset  out  1  core reset
- core_outState  in  N_BITS  core read data, valid 1 cycle after the rd strobe
- core_done  in  1  core finished (level)
- busy  out  1  state is not LOAD, or LOAD with word count > 0
- timeout_err  out  1  sticky, core_done not seen within DONE_TIMEOUT

Behaviour:
- Interface
  - Clock is clk. Reset is reset: synchronous, active-high.
  - On reset: state=CRST, word_cnt=0, rd_cnt=0, out_valid=0, out_last=0, core_wr=0, core_rd=0, core_enable=0, timeout_err=0. out_data and core_inState are don't-care.
- State CRST
  - core_reset=1 for exactly one cycle; all other core strobes are 0.
  - Next state: LOAD.
- State LOAD
  - in_ready=1.
  - On in_valid&&in_ready:
    - core_inState=in_data.
    - core_wr=2'b01 if word_cnt<39, else 2'b10.
    - word_cnt++.
  - Word k lands in bank k/39 at index k%39; index i*3+j is instance i, lane j.
  - core_wr and core_inState are combinational from the handshake, so the core captures the word on the same edge as the handshake.
  - After word_cnt reaches 78: in_ready=0 from the next cycle, next state START.
- State START
  - core_enable=1, held high through WAIT.
  - Next state: WAIT; timer=0.
- State WAIT
  - timer++ each cycle.
  - If core_done=1: core_enable=0 on the next cycle, next state DRAIN.
  - Else if DONE_TIMEOUT!=0 and timer==DONE_TIMEOUT-1: timeout_err<=1, next state CRST. The batch is dropped and no output is produced.
  - core_done takes priority if it coincides with the timeout cycle.
- State DRAIN
  - rd_cnt counts issued reads, 0..77. A flag marks a read in flight.
  - Issue a read at cycle t only if no read is in flight and (!out_valid || out_ready).
  - Read encoding: core_rd=2'b01 if rd_cnt<39, else 2'b10. rd_cnt++.
  - At t+1: out_data<=core_outState, out_valid<=1, out_last<=(rd_cnt==78). The in-flight flag clears.
  - Maximum throughput is 1 result per 2 cycles.
  - out_valid and out_data stay stable while out_ready=0.
  - When the word with out_last=1 is accepted: out_valid=0, next state CRST.
- Strobe rules
  - core_wr and core_rd are never nonzero together.
  - Never more than one bit of either is set.
  - core_rd is never asserted while out_valid&&!out_ready.
- Reset mid-operation
  - Any state returns to CRST.
  - Partial batch is discarded, out_valid drops to 0 immediately.
  - core_reset is asserted on the cycle after reset deasserts (CRST).
- Other boundaries
  - in_valid during non-LOAD states is ignored (in_ready=0).
  - core_done asserted before START is ignored.
  - in_valid low in LOAD stalls with no strobes.

Test Plan:
- Reset, then 78 back-to-back words 1..78 with core model done 10 cycles after enable → core_wr=01 for words 1..39 and 10 for 40..78. core_enable high from cycle after word 78 until done. Outputs in order, bank1 then bank2, out_last on the 78th. core_reset pulses once after the batch.
- Same batch with out_ready toggling 1-0-0-1 → no dropped or duplicated words; out_data stable while stalled; no core_rd during stall.
- in_valid gaps (every third cycle low) → word_cnt only advances on handshakes; core_wr=00 on gap cycles.
- DONE_TIMEOUT=16, core never asserts done → timeout_err=1 at timer 15; returns to CRST; no out_valid; next batch completes normally with timeout_err still 1.
- Reset asserted after 50 words loaded → out_valid=0, in_ready=0 during reset. One core_reset pulse. A fresh 78-word batch then routes word 1 to bank 1.
- Two consecutive batches → core_reset pulse between them; second batch results correct.
